// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 bus engine.
// The init ROM is only consulted when LCD_INIT_SEQ_EN is defined.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_LOAD,
    SETUP,
    EN_HI,
    HOLD,
    EXEC,
    IDLE
  } lcd_state_t;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_FUNCSET = 8'h38;
  localparam logic [7:0] CMD_DISPON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;

  localparam int INIT_LEN = 4;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{CMD_FUNCSET, CMD_DISPON, CMD_ENTRY, CMD_CLEAR};

  // Clear and both home encodings (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && (b == CMD_CLEAR || b == CMD_HOME || b == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter shared by every timed state of the bus engine.
// Holds at zero once expired; done is asserted while the count is zero.
module lcd_delay_cnt #(
  parameter int            CW      = 20,
  parameter logic [CW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= RST_VAL;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/lcd_bus_engine.sv
// HD44780 8-bit write-only bus timing engine with power-up wait.
// Define LCD_INIT_SEQ_EN to run the built-in 4-command init sequence.
module lcd_bus_engine
  import lcd_pkg::*;
#(
  parameter int T_PWRUP = 750000,
  parameter int T_SETUP = 2,
  parameter int T_EN    = 24,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2000,
  parameter int T_CLEAR = 82000,
  parameter int CW      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       init_done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db,
  output logic       lcd_rst
);

  localparam int T_MAX = (T_PWRUP > T_CLEAR) ? T_PWRUP : T_CLEAR;

  generate
    if (T_PWRUP < 1 || T_SETUP < 1 || T_EN < 1 || T_HOLD < 1 || T_EXEC < 1 || T_CLEAR < 1) begin : g_bad_zero
      $error("lcd_bus_engine: every T_* parameter must be at least 1");
    end
    if (longint'(T_MAX) >= (longint'(1) << CW) || T_EXEC > T_MAX || T_EN > T_MAX) begin : g_bad_cw
      $error("lcd_bus_engine: CW too narrow for the largest delay");
    end
  endgenerate

  localparam logic [CW-1:0] LD_PWRUP = CW'(T_PWRUP - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(T_EN - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LD_CLEAR = CW'(T_CLEAR - 1);

  lcd_state_t    state_reg, state_next;
  logic          rs_reg, rs_next;
  logic [7:0]    db_reg, db_next;
  logic          en_reg;
  logic          init_done_reg;
  logic          done_set;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_done;
`ifdef LCD_INIT_SEQ_EN
  logic [1:0]    idx_reg;
  logic          idx_inc;
`endif

  lcd_delay_cnt #(.CW(CW), .RST_VAL(LD_PWRUP)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_comb begin
    state_next = state_reg;
    rs_next    = rs_reg;
    db_next    = db_reg;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    done_set   = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    idx_inc    = 1'b0;
`endif
    case (state_reg)
      PWRUP: begin
        if (cnt_done) begin
`ifdef LCD_INIT_SEQ_EN
          state_next = INIT_LOAD;
`else
          state_next = IDLE;
          done_set   = 1'b1;
`endif
        end
      end
`ifdef LCD_INIT_SEQ_EN
      INIT_LOAD: begin
        rs_next    = 1'b0;
        db_next    = INIT_ROM[idx_reg];
        state_next = SETUP;
        cnt_load   = 1'b1;
        cnt_val    = LD_SETUP;
      end
`endif
      SETUP: begin
        if (cnt_done) begin
          state_next = EN_HI;
          cnt_load   = 1'b1;
          cnt_val    = LD_EN;
        end
      end
      EN_HI: begin
        if (cnt_done) begin
          state_next = HOLD;
          cnt_load   = 1'b1;
          cnt_val    = LD_HOLD;
        end
      end
      HOLD: begin
        if (cnt_done) begin
          state_next = EXEC;
          cnt_load   = 1'b1;
          cnt_val    = is_long_cmd(rs_reg, db_reg) ? LD_CLEAR : LD_EXEC;
        end
      end
      EXEC: begin
        if (cnt_done) begin
          state_next = IDLE;
`ifdef LCD_INIT_SEQ_EN
          if (!init_done_reg) begin
            if (idx_reg == 2'd3) begin
              done_set = 1'b1;
            end else begin
              idx_inc    = 1'b1;
              state_next = INIT_LOAD;
            end
          end
`endif
        end
      end
      IDLE: begin
        // Bus registers only change here and in INIT_LOAD, i.e. on entry to SETUP.
        if (in_valid) begin
          rs_next    = in_rs;
          db_next    = in_data;
          state_next = SETUP;
          cnt_load   = 1'b1;
          cnt_val    = LD_SETUP;
        end
      end
      default: state_next = PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= PWRUP;
      rs_reg        <= 1'b0;
      db_reg        <= 8'h00;
      en_reg        <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      rs_reg    <= rs_next;
      db_reg    <= db_next;
      en_reg    <= (state_next == EN_HI);
      if (done_set) init_done_reg <= 1'b1;
    end
  end

`ifdef LCD_INIT_SEQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= 2'd0;
    end else if (idx_inc) begin
      idx_reg <= idx_reg + 2'd1;
    end
  end
`endif

  assign in_ready  = (state_reg == IDLE);
  assign init_done = init_done_reg;
  assign lcd_en    = en_reg;
  assign lcd_rs    = rs_reg;
  assign lcd_rw    = 1'b0;
  assign lcd_db    = db_reg;
  assign lcd_rst   = ~rst;

endmodule

// File: tb/tb_lcd_bus_engine.sv
// Directed bench for lcd_bus_engine using short sim timings; outputs sampled on negedge.
// Expectations follow LCD_INIT_SEQ_EN the same way the RTL does.
module tb_lcd_bus_engine;

  localparam int T_PWRUP = 20;
  localparam int T_SETUP = 2;
  localparam int T_EN    = 4;
  localparam int T_HOLD  = 2;
  localparam int T_EXEC  = 10;
  localparam int T_CLEAR = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, init_done, lcd_en, lcd_rs, lcd_rw, lcd_rst;
  logic [7:0] lcd_db;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lcd_bus_engine #(
    .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
    .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR), .CW(20)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs(in_rs), .in_data(in_data),
    .in_ready(in_ready), .init_done(init_done), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_db(lcd_db), .lcd_rst(lcd_rst)
  );

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (lcd_en !== 1'b0)    begin bad++; $display("FAIL reset_en got=%0b want=0", lcd_en); end
    total++; if (lcd_rs !== 1'b0)    begin bad++; $display("FAIL reset_rs got=%0b want=0", lcd_rs); end
    total++; if (lcd_db !== 8'h00)   begin bad++; $display("FAIL reset_db got=%02h want=00", lcd_db); end
    total++; if (lcd_rw !== 1'b0)    begin bad++; $display("FAIL reset_rw got=%0b want=0", lcd_rw); end
    total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL reset_ready got=%0b want=0", in_ready); end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done got=%0b want=0", init_done); end
    total++; if (lcd_rst !== 1'b0)   begin bad++; $display("FAIL reset_lcd_rst got=%0b want=0", lcd_rst); end
    $display("reset: en=%0b rs=%0b db=%02h ready=%0b init_done=%0b", lcd_en, lcd_rs, lcd_db, in_ready, init_done);
  endtask

  // Releases rst at the current negedge and follows the power-up (and init) sequence into IDLE.
  task automatic test_power_up();
    int n, w, g, errs;
    logic [7:0] rom [4];
    rom = '{8'h38, 8'h0C, 8'h06, 8'h01};
    rst = 1'b0;
    #1;
    total++; if (lcd_rst !== 1'b1) begin bad++; $display("FAIL pwrup_lcd_rst got=%0b want=1", lcd_rst); end
`ifdef LCD_INIT_SEQ_EN
    n = 0;
    do begin @(negedge clk); n++; end while (lcd_en !== 1'b1 && n < 200);
    total++; if (n != 23) begin bad++; $display("FAIL pwrup_first_rise got=%0d want=23", n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (lcd_rs !== 1'b0 || lcd_db !== rom[i]) begin
        bad++; $display("FAIL init_byte%0d got=rs%0b/%02h want=rs0/%02h", i, lcd_rs, lcd_db, rom[i]);
      end
      w = 1;
      forever begin @(negedge clk); if (lcd_en === 1'b1 && w < 100) w++; else break; end
      total++; if (w != 4) begin bad++; $display("FAIL init_width%0d got=%0d want=4", i, w); end
      $display("init pulse %0d: rs=%0b db=%02h width=%0d", i, lcd_rs, lcd_db, w);
      if (i < 3) begin
        g = 1;
        forever begin @(negedge clk); if (lcd_en !== 1'b1 && g < 200) g++; else break; end
        total++; if (g != 15) begin bad++; $display("FAIL init_gap%0d got=%0d want=15", i, g); end
      end else begin
        errs = 0;
        repeat (31) begin
          @(negedge clk);
          if (init_done !== 1'b0 || in_ready !== 1'b0 || lcd_en !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL init_clear_wait got=%0d early cycles want=0", errs); end
        @(negedge clk);
        total++; if (init_done !== 1'b1) begin bad++; $display("FAIL init_done_rise got=%0b want=1", init_done); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL init_ready got=%0b want=1", in_ready); end
      end
    end
`else
    errs = 0;
    repeat (19) begin
      @(negedge clk);
      if (init_done !== 1'b0 || in_ready !== 1'b0 || lcd_en !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL pwrup_early got=%0d early cycles want=0", errs); end
    @(negedge clk);
    total++; if (init_done !== 1'b1) begin bad++; $display("FAIL pwrup_init_done got=%0b want=1", init_done); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL pwrup_ready got=%0b want=1", in_ready); end
    errs = 0;
    repeat (40) begin @(negedge clk); if (lcd_en !== 1'b0 || in_ready !== 1'b1) errs++; end
    total++; if (errs != 0) begin bad++; $display("FAIL pwrup_no_pulse got=%0d bad cycles want=0", errs); end
`endif
    $display("power-up: init_done=%0b ready=%0b", init_done, in_ready);
  endtask

  task automatic test_single_write();
    int errs;
    logic exp_en;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_pre_ready got=%0b want=1", in_ready); end
    in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h41;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL single_ready_drop got=%0b want=0", in_ready); end
    in_valid = 1'b0; in_rs = 1'b0; in_data = 8'hFF;
    errs = 0;
    for (int s = 1; s <= 8; s++) begin
      if (s > 1) @(negedge clk);
      exp_en = (s >= 3 && s <= 6);
      if (lcd_en !== exp_en || lcd_rs !== 1'b1 || lcd_db !== 8'h41 || in_ready !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL single_bus_timing got=%0d bad cycles want=0", errs); end
    errs = 0;
    for (int s = 9; s <= 18; s++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || lcd_en !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL single_exec_wait got=%0d bad cycles want=0", errs); end
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready_return got=%0b want=1", in_ready); end
    total++; if (lcd_db !== 8'h41 || lcd_rs !== 1'b1) begin
      bad++; $display("FAIL single_bus_hold got=rs%0b/%02h want=rs1/41", lcd_rs, lcd_db);
    end
    $display("single write: rs=%0b db=%02h ready=%0b", lcd_rs, lcd_db, in_ready);
  endtask

  task automatic test_exec_wait();
    logic       t_rs [6];
    logic [7:0] t_db [6];
    int         t_n  [6];
    int n, pulses;
    logic prev;
    // cycles from accept to in_ready again = T_SETUP+T_EN+T_HOLD+exec+1
    t_rs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    t_db = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h02};
    t_n  = '{39, 19, 39, 39, 19, 19};
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_rs = t_rs[i]; in_data = t_db[i];
      @(negedge clk);
      in_valid = 1'b0;
      n = 1; pulses = 0; prev = 1'b0;
      while (in_ready !== 1'b1 && n < 300) begin
        if (lcd_en === 1'b1 && !prev) pulses++;
        prev = lcd_en;
        @(negedge clk);
        n++;
      end
      total++; if (n != t_n[i]) begin
        bad++; $display("FAIL exec_len rs%0b/%02h got=%0d want=%0d", t_rs[i], t_db[i], n, t_n[i]);
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL exec_pulses%0d got=%0d want=1", i, pulses); end
      $display("exec: rs=%0b db=%02h cycles=%0d pulses=%0d", t_rs[i], t_db[i], n, pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [3];
    logic [7:0] got [$];
    int rise_t [$];
    int n, k;
    logic hs, prev;
    b = '{8'h48, 8'h69, 8'h21};
    k = 0; n = 0; prev = 1'b0;
    in_valid = 1'b1; in_rs = 1'b1; in_data = b[0];
    hs = (in_ready === 1'b1);
    while (n < 200 && !(k == 3 && in_ready === 1'b1)) begin
      @(negedge clk);
      n++;
      if (hs) begin
        k++;
        if (k < 3) in_data = b[k];
        else in_valid = 1'b0;
      end
      if (lcd_en === 1'b1 && !prev) begin
        got.push_back(lcd_db);
        rise_t.push_back(n);
        if (lcd_rs !== 1'b1) begin
          total++; bad++; $display("FAIL b2b_rs got=%0b want=1", lcd_rs);
        end
      end
      prev = lcd_en;
      hs = (in_valid === 1'b1 && in_ready === 1'b1);
    end
    total++; if (got.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++; if (got[i] !== b[i]) begin bad++; $display("FAIL b2b_byte%0d got=%02h want=%02h", i, got[i], b[i]); end
      $display("b2b byte %0d: db=%02h t=%0d", i, got[i], rise_t[i]);
    end
    for (int i = 1; i < 3 && i < rise_t.size(); i++) begin
      total++; if (rise_t[i] - rise_t[i-1] != 19) begin
        bad++; $display("FAIL b2b_spacing%0d got=%0d want=19", i, rise_t[i] - rise_t[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (lcd_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (lcd_en !== 1'b1) begin bad++; $display("FAIL mid_reach_en got=%0b want=1", lcd_en); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (lcd_en !== 1'b0)    begin bad++; $display("FAIL mid_en got=%0b want=0", lcd_en); end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL mid_init_done got=%0b want=0", init_done); end
    total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL mid_ready got=%0b want=0", in_ready); end
    total++; if (lcd_db !== 8'h00)   begin bad++; $display("FAIL mid_db got=%02h want=00", lcd_db); end
    $display("mid reset: en=%0b init_done=%0b ready=%0b", lcd_en, init_done, in_ready);
    test_power_up();
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_single_write();
    test_exec_wait();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
